// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stalls,
// redirect flushes and a sticky halt, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int         REG_BITS     = 3,
  parameter int         N_READ       = 2,
  parameter int         LOAD_LAT     = 1,
  parameter int         FLUSH_CYCLES = 1,
  parameter logic [2:0] HALT_OP      = 3'b111
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_READ*REG_BITS-1:0]   id_rs,
  input  logic [N_READ-1:0]            id_rs_used,
  input  logic [2:0]                   id_opcode,
  input  logic [REG_BITS-1:0]          id_ex_rd,
  input  logic                         id_ex_load,
  input  logic [REG_BITS-1:0]          ex_mem_rd,
  input  logic                         ex_mem_write,
  input  logic [REG_BITS-1:0]          mem_wb_rd,
  input  logic                         mem_wb_write,
  input  logic                         redirect,
  output logic                         pc_load,
  output logic                         if_id_hold,
  output logic                         if_id_flush,
  output logic                         id_ex_bubble,
  output logic [2*N_READ-1:0]          forward,
  output logic                         halted,
  output logic [15:0]                  stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_e;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;
  logic [N_READ-1:0] luHit;
  logic        loadUse;
  logic        enterFlush;

  // Per-port forwarding and load-use detection; EX/MEM beats MEM/WB.
  for (genvar k = 0; k < N_READ; k++) begin : g_port
    logic [REG_BITS-1:0] rsK;
    logic                exMemHit;
    logic                memWbHit;

    assign rsK      = id_rs[k*REG_BITS +: REG_BITS];
    assign exMemHit = ex_mem_write && (ex_mem_rd != '0) && (ex_mem_rd == rsK);
    assign memWbHit = mem_wb_write && (mem_wb_rd != '0) && (mem_wb_rd == rsK);
    assign luHit[k] = id_rs_used[k] && id_ex_load && (id_ex_rd != '0) && (id_ex_rd == rsK);

    always_comb begin
      forward[2*k +: 2] = 2'b00;
      if (id_rs_used[k]) begin
        if (exMemHit) begin
          forward[2*k +: 2] = 2'b10;
        end else if (memWbHit) begin
          forward[2*k +: 2] = 2'b01;
        end
      end
    end
  end

  assign loadUse = |luHit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_load      = 1'b1;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    enterFlush   = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect) begin
          enterFlush = 1'b1;
        end else if (id_opcode == HALT_OP) begin
          pc_load      = 1'b0;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          state_d      = HALT;
        end else if (loadUse) begin
          pc_load      = 1'b0;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end

      STALL: begin
        if (redirect) begin
          enterFlush = 1'b1;
        end else begin
          pc_load      = 1'b0;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          // A zero count can only be reached by a corrupted state; leave safely.
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      FLUSH: begin
        if (redirect) begin
          enterFlush = 1'b1;
        end else begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      HALT: begin
        pc_load      = 1'b0;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
        halted       = 1'b1;
      end

      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase

    // Redirects from RUN, STALL or FLUSH all (re)start the wrong-path flush.
    if (enterFlush) begin
      pc_load      = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_load && (state_q != HALT) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// traffic, all compared against a countdown-based behavioural model.
module tb_hazard_ctrl;

  localparam int         RB  = 3;
  localparam int         NR  = 2;
  localparam int         LL  = 3;
  localparam int         FC  = 2;
  localparam logic [2:0] HOP = 3'b111;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*RB-1:0]  id_rs;
  logic [NR-1:0]     id_rs_used;
  logic [2:0]        id_opcode;
  logic [RB-1:0]     id_ex_rd;
  logic              id_ex_load;
  logic [RB-1:0]     ex_mem_rd;
  logic              ex_mem_write;
  logic [RB-1:0]     mem_wb_rd;
  logic              mem_wb_write;
  logic              redirect;
  logic              pc_load;
  logic              if_id_hold;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [2*NR-1:0]   forward;
  logic              halted;
  logic [15:0]       stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_BITS(RB), .N_READ(NR), .LOAD_LAT(LL), .FLUSH_CYCLES(FC), .HALT_OP(HOP)
  ) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_opcode(id_opcode), .id_ex_rd(id_ex_rd), .id_ex_load(id_ex_load),
    .ex_mem_rd(ex_mem_rd), .ex_mem_write(ex_mem_write), .mem_wb_rd(mem_wb_rd),
    .mem_wb_write(mem_wb_write), .redirect(redirect), .pc_load(pc_load),
    .if_id_hold(if_id_hold), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .forward(forward), .halted(halted), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Model state: remaining stall/flush cycles, sticky halt, stall counter.
  int mStallLeft, mFlushLeft, mStallCnt;
  bit mHalted;
  int nStallLeft, nFlushLeft;
  bit nHalted;
  bit ePc, eHold, eFlush, eBubble, eHalted;
  logic [2*NR-1:0] eFwd;

  logic obsPc, obsHold, obsFlush, obsBubble, obsHalted;
  logic [2*NR-1:0] obsFwd;
  logic [15:0] obsStall;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelEval();
    bit lu;
    logic [RB-1:0] rs;
    lu   = 1'b0;
    eFwd = '0;
    for (int k = 0; k < NR; k++) begin
      rs = id_rs[k*RB +: RB];
      if (id_rs_used[k]) begin
        if (id_ex_load && id_ex_rd != 0 && id_ex_rd == rs) lu = 1'b1;
        if (ex_mem_write && ex_mem_rd != 0 && ex_mem_rd == rs) eFwd[2*k +: 2] = 2'b10;
        else if (mem_wb_write && mem_wb_rd != 0 && mem_wb_rd == rs) eFwd[2*k +: 2] = 2'b01;
      end
    end
    ePc = 1; eHold = 0; eFlush = 0; eBubble = 0; eHalted = 0;
    nStallLeft = mStallLeft; nFlushLeft = mFlushLeft; nHalted = mHalted;
    if (mHalted) begin
      ePc = 0; eHold = 1; eBubble = 1; eHalted = 1;
    end else if (redirect) begin
      eFlush = 1; eBubble = 1;
      nFlushLeft = FC - 1;
      nStallLeft = 0;
    end else if (mFlushLeft > 0) begin
      eFlush = 1; eBubble = 1;
      nFlushLeft = mFlushLeft - 1;
    end else if (mStallLeft > 0) begin
      ePc = 0; eHold = 1; eBubble = 1;
      nStallLeft = mStallLeft - 1;
    end else if (id_opcode == HOP) begin
      ePc = 0; eHold = 1; eBubble = 1;
      nHalted = 1;
    end else if (lu) begin
      ePc = 0; eHold = 1; eBubble = 1;
      nStallLeft = LL - 1;
    end
  endtask

  // One clock: sample and check outputs mid-cycle, then advance the model.
  task automatic applyStimulus();
    #1;
    obsPc = pc_load; obsHold = if_id_hold; obsFlush = if_id_flush;
    obsBubble = id_ex_bubble; obsHalted = halted; obsFwd = forward; obsStall = stall_cycles;
    modelEval();
    checkOutput("pc_load", 32'(obsPc), 32'(ePc));
    checkOutput("if_id_hold", 32'(obsHold), 32'(eHold));
    checkOutput("if_id_flush", 32'(obsFlush), 32'(eFlush));
    checkOutput("id_ex_bubble", 32'(obsBubble), 32'(eBubble));
    checkOutput("halted", 32'(obsHalted), 32'(eHalted));
    checkOutput("forward", 32'(obsFwd), 32'(eFwd));
    checkOutput("stall_cycles", 32'(obsStall), 32'(mStallCnt));
    @(posedge clk);
    if (reset) begin
      mStallLeft = 0; mFlushLeft = 0; mHalted = 0; mStallCnt = 0;
    end else begin
      if (!ePc && !mHalted && mStallCnt < 65535) mStallCnt++;
      mStallLeft = nStallLeft; mFlushLeft = nFlushLeft; mHalted = nHalted;
    end
    @(negedge clk);
  endtask

  task automatic clearInputs();
    id_rs = '0; id_rs_used = '0; id_opcode = 3'd0; id_ex_rd = '0; id_ex_load = 0;
    ex_mem_rd = '0; ex_mem_write = 0; mem_wb_rd = '0; mem_wb_write = 0; redirect = 0;
  endtask

  task automatic setLoadUse();
    id_ex_load = 1; id_ex_rd = 3'd2; id_rs[5:3] = 3'd2; id_rs_used = 2'b10;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1;
    applyStimulus();
    reset = 0;
  endtask

  initial begin
    clearInputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    mStallLeft = 0; mFlushLeft = 0; mHalted = 0; mStallCnt = 0;

    $display("[TB] reset state");
    applyStimulus();
    checkOutput("rst_pc_load", 32'(obsPc), 32'd1);
    checkOutput("rst_halted", 32'(obsHalted), 32'd0);
    checkOutput("rst_stall_cycles", 32'(obsStall), 32'd0);

    $display("[TB] forwarding priority");
    id_rs[2:0] = 3'd3; id_rs_used = 2'b01;
    ex_mem_rd = 3'd3; ex_mem_write = 1; mem_wb_rd = 3'd3; mem_wb_write = 1;
    applyStimulus();
    checkOutput("fwd_exmem", 32'(obsFwd[1:0]), 32'h2);
    ex_mem_write = 0;
    applyStimulus();
    checkOutput("fwd_memwb", 32'(obsFwd[1:0]), 32'h1);
    id_rs[2:0] = 3'd0;
    applyStimulus();
    checkOutput("fwd_regfile", 32'(obsFwd[1:0]), 32'h0);

    $display("[TB] load-use stall");
    clearInputs();
    setLoadUse();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("lu_stall_pc", 32'(obsPc), 32'd0);
    end
    clearInputs();
    applyStimulus();
    checkOutput("lu_done_pc", 32'(obsPc), 32'd1);
    checkOutput("lu_stall_count", 32'(obsStall), 32'd3);

    $display("[TB] redirect during stall");
    doReset();
    setLoadUse();
    applyStimulus();
    redirect = 1;
    applyStimulus();
    checkOutput("stall_redir_flush", 32'(obsFlush), 32'd1);
    checkOutput("stall_redir_pc", 32'(obsPc), 32'd1);
    redirect = 0;
    applyStimulus();
    checkOutput("stall_redir_after_pc", 32'(obsPc), 32'd1);
    clearInputs();
    applyStimulus();
    checkOutput("stall_redir_count", 32'(obsStall), 32'd1);

    $display("[TB] flush length");
    doReset();
    redirect = 1;
    applyStimulus();
    checkOutput("flush_c1", 32'(obsFlush), 32'd1);
    redirect = 0;
    applyStimulus();
    checkOutput("flush_c2", 32'(obsFlush), 32'd1);
    applyStimulus();
    checkOutput("flush_c3_off", 32'(obsFlush), 32'd0);
    redirect = 1;
    applyStimulus();
    applyStimulus();
    redirect = 0;
    applyStimulus();
    checkOutput("flush_ext_c3", 32'(obsFlush), 32'd1);
    applyStimulus();
    checkOutput("flush_ext_c4_off", 32'(obsFlush), 32'd0);

    $display("[TB] halt");
    doReset();
    id_opcode = HOP;
    applyStimulus();
    checkOutput("halt_dec_pc", 32'(obsPc), 32'd0);
    checkOutput("halt_dec_halted", 32'(obsHalted), 32'd0);
    id_opcode = 3'd0;
    redirect = 1;
    setLoadUse();
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("halt_halted", 32'(obsHalted), 32'd1);
      checkOutput("halt_flush", 32'(obsFlush), 32'd0);
      checkOutput("halt_stall_frozen", 32'(obsStall), 32'd1);
    end
    doReset();
    applyStimulus();
    checkOutput("halt_reset_halted", 32'(obsHalted), 32'd0);
    checkOutput("halt_reset_stall", 32'(obsStall), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      reset        = ($urandom_range(39) == 0);
      id_rs        = NR*RB'($urandom);
      id_rs_used   = NR'($urandom);
      id_opcode    = ($urandom_range(29) == 0) ? HOP : 3'($urandom_range(6));
      id_ex_rd     = RB'($urandom);
      id_ex_load   = ($urandom_range(2) == 0);
      ex_mem_rd    = RB'($urandom);
      ex_mem_write = 1'($urandom);
      mem_wb_rd    = RB'($urandom);
      mem_wb_write = 1'($urandom);
      redirect     = ($urandom_range(7) == 0);
      applyStimulus();
    end
    reset = 0;

    $display("[TB] counter saturation");
    doReset();
    setLoadUse();
    for (int i = 0; i < 65540; i++) begin
      applyStimulus();
    end
    applyStimulus();
    checkOutput("stall_saturated", 32'(obsStall), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_BITS, default 3: register-index width (legal range 2..5).
REQ-002 Parameter N_READ, default 2: number of ID-stage source-read ports (legal range 1..4).
REQ-003 Parameter LOAD_LAT, default 1: load-use stall cycles (legal range 1..7).
REQ-004 Parameter FLUSH_CYCLES, default 1: wrong-path flush cycles after a redirect (legal range 1..7).
REQ-005 Parameter HALT_OP, default 3'b111: opcode value that halts the pipeline.
REQ-006 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port id_rs, input, N_READ*REG_BITS: ID-stage source indices; port k occupies bits [k*REG_BITS +: REG_BITS].
REQ-009 Port id_rs_used, input, N_READ: bit k set means source k is actually read.
REQ-010 Port id_opcode, input, 3: opcode of the instruction in ID.
REQ-011 Port id_ex_rd, input, REG_BITS: destination register in EX.
REQ-012 Port id_ex_load, input, 1: the instruction in EX is a load.
REQ-013 Port ex_mem_rd, input, REG_BITS: destination register in MEM.
REQ-014 Port ex_mem_write, input, 1: the instruction in MEM writes the register file.
REQ-015 Port mem_wb_rd, input, REG_BITS: destination register in WB.
REQ-016 Port mem_wb_write, input, 1: the instruction in WB writes the register file.
REQ-017 Port redirect, input, 1: a taken branch or jump was resolved this cycle.
REQ-018 Port pc_load, output, 1: PC update enable.
REQ-019 Port if_id_hold, output, 1: hold the IF/ID register.
REQ-020 Port if_id_flush, output, 1: clear the IF/ID register.
REQ-021 Port id_ex_bubble, output, 1: insert a NOP into ID/EX.
REQ-022 Port forward, output, 2*N_READ: per-port forward select; 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-023 Port halted, output, 1: the pipeline is halted.
REQ-024 Port stall_cycles, output, 16: performance counter of stall cycles.

Function
REQ-025 Forwarding is combinational and independent of FSM state.
- Port k selects 10 if ex_mem_write, ex_mem_rd != 0 and ex_mem_rd == rs_k.
- Otherwise port k selects 01 if mem_wb_write, mem_wb_rd != 0 and mem_wb_rd == rs_k.
- Otherwise port k selects 00.
- Ports with id_rs_used[k] = 0 always select 00.
REQ-026 The FSM has four states: RUN, STALL, FLUSH, HALT, plus a 3-bit down-counter cnt.
REQ-027 Default outputs: pc_load = 1; if_id_hold, if_id_flush, id_ex_bubble and halted = 0.
REQ-028 Load-use hazard (lu) is asserted when id_ex_load = 1, id_ex_rd != 0, and id_ex_rd equals some used rs_k.
REQ-029 In RUN, conditions are evaluated in priority order redirect > halt-decode > lu.
REQ-030 RUN with redirect:
- Outputs: if_id_flush = 1, id_ex_bubble = 1, pc_load = 1.
- If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES - 1; otherwise stay in RUN.
REQ-031 RUN with id_opcode == HALT_OP and no redirect:
- Outputs: pc_load = 0, if_id_hold = 1, id_ex_bubble = 1 in the same cycle.
- Next state is HALT.
REQ-032 RUN with lu, no redirect and no halt-decode:
- Outputs: pc_load = 0, if_id_hold = 1, id_ex_bubble = 1.
- If LOAD_LAT > 1, go to STALL with cnt = LOAD_LAT - 1; otherwise stay in RUN.
REQ-033 STALL:
- Outputs: same as the lu case; cnt decrements each cycle.
- Return to RUN on the cycle in which cnt == 1.
- A redirect in STALL overrides: apply REQ-030 outputs and transitions.
REQ-034 FLUSH:
- Outputs: if_id_flush = 1, id_ex_bubble = 1, pc_load = 1; cnt decrements each cycle.
- Return to RUN when cnt == 1.
- A new redirect in FLUSH reloads cnt = FLUSH_CYCLES - 1 (goes to RUN if FLUSH_CYCLES == 1).
REQ-035 HALT:
- Outputs: pc_load = 0, if_id_hold = 1, id_ex_bubble = 1, halted = 1.
- All inputs are ignored; HALT is exited only by reset.
REQ-036 stall_cycles increments by 1 on each clock where pc_load == 0 and state != HALT, saturating at 16'hFFFF.

Reset
REQ-037 While reset = 1 at the clock edge:
- state <= RUN, cnt <= 0, stall_cycles <= 0.
- This applies mid-STALL, mid-FLUSH and in HALT.
REQ-038 Outputs are combinational from the post-reset state, so the first cycle after reset shows the default outputs (REQ-027) and forward = 00 unless the hazard inputs dictate otherwise.

Verification
REQ-039 Forwarding priority: ex_mem_rd = mem_wb_rd = 3, both write enables = 1, rs0 = 3, used -> forward[1:0] = 10; drop ex_mem_write -> 01; set rs0 = 0 -> 00.
REQ-040 Load-use with LOAD_LAT = 3: id_ex_load = 1, id_ex_rd = 2, rs1 = 2 used -> pc_load = 0 for exactly 3 cycles, then RUN; stall_cycles = 3.
REQ-041 Redirect during STALL (LOAD_LAT = 3, redirect on the 2nd stall cycle) -> if_id_flush = 1 and pc_load = 1 that cycle; no further stall cycles.
REQ-042 FLUSH_CYCLES = 2: redirect pulse -> if_id_flush high for 2 cycles; a second redirect in the 2nd cycle extends the flush to 3 cycles total.
REQ-043 HALT: id_opcode = 3'b111 -> pc_load = 0 that cycle, halted = 1 from the next cycle; redirect and lu then ignored; stall_cycles frozen; reset -> halted = 0, stall_cycles = 0.
REQ-044 Saturation: hold lu true for 65540 cycles -> stall_cycles = 16'hFFFF and does not wrap.
